// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU, AUX and memory-side signals of the data-memory arbiter.
// Latency: none (wires only).
// Backpressure: none here; cpu_stall and aux_ack carry the flow control.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU (pipeline MEM stage) port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Auxiliary master port
    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic [DATA_W-1:0] aux_rdata;
    logic              aux_ack;

    // Single-port synchronous memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_rdata, aux_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    // Environment view (requesters and memory)
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_rdata, aux_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data memory between the CPU MEM stage and an auxiliary master.
// Latency: 3 cycles per access (arbitrate, memory access, done); never more than one access in flight.
// Backpressure: CPU is held by cpu_stall until its done cycle; AUX holds its request until aux_ack.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_C_ACC  = 3'd1,
        S_C_DONE = 3'd2,
        S_A_ACC  = 3'd3,
        S_A_DONE = 3'd4
    } state_t;

    // AUX is forced through once it has lost this many arbitrations in a row
    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);
    localparam logic [7:0] LOSS_SAT   = 8'd255;

    state_t            state_q, state_d;
    logic [7:0]        losses_q, losses_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              aux_win, cpu_win;

    // Arbitration: CPU has priority unless AUX has been starved long enough
    always_comb begin
        aux_win = 1'b0;
        cpu_win = 1'b0;
        if (state_q == S_IDLE) begin
            aux_win = bus.aux_req & (~bus.cpu_req | (losses_q >= MAX_WAIT_L));
            cpu_win = bus.cpu_req & ~aux_win;
        end
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed three-cycle walk per granted access
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (aux_win) begin
                    state_d = S_A_ACC;
                end else if (cpu_win) begin
                    state_d = S_C_ACC;
                end
            end
            S_C_ACC:  state_d = S_C_DONE;
            S_C_DONE: state_d = S_IDLE;
            S_A_ACC:  state_d = S_A_DONE;
            S_A_DONE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Memory command and loss counter next values; winner's fields are captured in IDLE
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        losses_d    = losses_q;
        if (aux_win) begin
            mem_en_d    = 1'b1;
            mem_we_d    = bus.aux_we;
            mem_addr_d  = bus.aux_addr;
            mem_wdata_d = bus.aux_wdata;
            losses_d    = 8'd0;
        end else if (cpu_win) begin
            mem_en_d    = 1'b1;
            mem_we_d    = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            // Only a lost arbitration counts; saturate rather than wrap
            if (bus.aux_req && (losses_q != LOSS_SAT)) begin
                losses_d = losses_q + 8'd1;
            end
        end
    end

    // Memory command and loss counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            losses_q    <= 8'd0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            losses_q    <= losses_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Requester-facing outputs decoded from state; read data steered only in the done cycle
    always_comb begin
        bus.cpu_rdata = '0;
        bus.aux_rdata = '0;
        bus.aux_ack   = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        // Stall covers waiting on AUX as well as the CPU's own arbitrate/access cycles
        bus.cpu_stall = bus.cpu_req & (state_q != S_C_DONE);
        case (state_q)
            S_C_DONE: bus.cpu_rdata = bus.mem_rdata;
            S_A_DONE: begin
                bus.aux_rdata = bus.mem_rdata;
                bus.aux_ack   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic clock = 1'b0;
    logic reset;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Environment memory: 64 words, synchronous read, write at the edge
    logic [31:0] ram [0:63];
    always @(posedge clock) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:2]] = bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[7:2]];
        end
    end

    // Transaction-level model: one access at a time, m_left cycles still to go after arbitration
    logic [31:0] ref_mem [0:63];
    int          m_left  = 0;
    int          m_owner = 0;     // 0 = CPU, 1 = AUX
    int          m_loss  = 0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    bit          cpu_fin = 1'b0;
    bit          aux_fin = 1'b0;
    bit          chk_en  = 1'b0;

    always @(posedge clock) begin : model
        bit a_w, c_w;
        cpu_fin = (m_left == 1) && (m_owner == 0);
        aux_fin = (m_left == 1) && (m_owner == 1);
        if (reset) begin
            m_left = 0;
            m_loss = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else begin
            a_w = bus.aux_req && (!bus.cpu_req || m_loss >= MAX_WAIT);
            c_w = bus.cpu_req && !a_w;
            if (a_w || c_w) begin
                if (a_w) m_loss = 0;
                else if (bus.aux_req) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                m_owner = a_w ? 1 : 0;
                m_we    = a_w ? bus.aux_we    : bus.cpu_we;
                m_addr  = a_w ? bus.aux_addr  : bus.cpu_addr;
                m_wdata = a_w ? bus.aux_wdata : bus.cpu_wdata;
                if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
                else      m_rdata = ref_mem[m_addr[7:2]];
                m_left = 2;
            end
        end
        chk_en = 1'b1;
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clock) begin : cmp
        bit c_done, a_done;
        if (chk_en) begin
            c_done = (m_left == 1) && (m_owner == 0);
            a_done = (m_left == 1) && (m_owner == 1);
            chk("busy",      32'(bus.busy),      32'(m_left != 0));
            chk("mem_en",    32'(bus.mem_en),    32'(m_left == 2));
            chk("aux_ack",   32'(bus.aux_ack),   32'(a_done));
            chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !c_done));
            if (m_left == 2) begin
                chk("mem_we",   32'(bus.mem_we), 32'(m_we));
                chk("mem_addr", bus.mem_addr,    m_addr);
                if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (c_done) begin
                if (!m_we) chk("cpu_rdata", bus.cpu_rdata, m_rdata);
            end else begin
                chk("cpu_rdata_idle", bus.cpu_rdata, 32'h0);
            end
            if (a_done) begin
                if (!m_we) chk("aux_rdata", bus.aux_rdata, m_rdata);
            end else begin
                chk("aux_rdata_idle", bus.aux_rdata, 32'h0);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin : main
        logic [5:0]  acks;
        logic [5:0]  stalls;
        logic [9:0]  grants;
        int          n;
        logic [31:0] w;
        reset         = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.aux_req   = 1'b1;
        bus.aux_we    = 1'b0;
        bus.aux_addr  = '0;
        bus.aux_wdata = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 64; i++) begin
            w          = $urandom;
            ram[i]     = w;
            ref_mem[i] = w;
        end

        // Reset held with both requests high: everything quiet
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("rst_busy",      32'(bus.busy),    32'h0);
            chk("rst_mem_en",    32'(bus.mem_en),  32'h0);
            chk("rst_mem_we",    32'(bus.mem_we),  32'h0);
            chk("rst_aux_ack",   32'(bus.aux_ack), 32'h0);
            chk("rst_mem_addr",  bus.mem_addr,     32'h0);
            chk("rst_mem_wdata", bus.mem_wdata,    32'h0);
            chk("rst_cpu_rdata", bus.cpu_rdata,    32'h0);
            chk("rst_aux_rdata", bus.aux_rdata,    32'h0);
        end
        tick;
        reset       = 1'b0;
        bus.cpu_req = 1'b0;
        bus.aux_req = 1'b0;
        tick;

        // CPU read of 0x10
        ram[4]       = 32'hDEADBEEF;
        ref_mem[4]   = 32'hDEADBEEF;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h10;
        @(negedge clock);
        chk("t2_stall_c0", 32'(bus.cpu_stall), 32'h1);
        chk("t2_en_c0",    32'(bus.mem_en),    32'h0);
        tick;
        @(negedge clock);
        chk("t2_stall_c1", 32'(bus.cpu_stall), 32'h1);
        chk("t2_en_c1",    32'(bus.mem_en),    32'h1);
        tick;
        @(negedge clock);
        chk("t2_stall_c2", 32'(bus.cpu_stall), 32'h0);
        chk("t2_en_c2",    32'(bus.mem_en),    32'h0);
        chk("t2_rdata",    bus.cpu_rdata,      32'hDEADBEEF);
        tick;
        bus.cpu_req = 1'b0;

        // AUX write 0x20 then AUX read 0x20 back to back
        bus.aux_req   = 1'b1;
        bus.aux_we    = 1'b1;
        bus.aux_addr  = 32'h20;
        bus.aux_wdata = 32'h12345678;
        acks = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            acks[i] = bus.aux_ack;
            if (i == 5) chk("t3_rdata", bus.aux_rdata, 32'h12345678);
            tick;
            if (i == 2) bus.aux_we = 1'b0;
        end
        bus.aux_req = 1'b0;
        chk("t3_acks", 32'(acks), 32'h24);

        // Both held high: four CPU grants then one forced AUX grant, repeating
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h80;
        bus.aux_req  = 1'b1;
        bus.aux_we   = 1'b0;
        bus.aux_addr = 32'h84;
        grants = '0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (bus.mem_en) begin
                if (n < 10) grants[n] = (bus.mem_addr == 32'h84);
                n++;
            end
            tick;
        end
        bus.cpu_req = 1'b0;
        bus.aux_req = 1'b0;
        chk("t4_order", 32'(grants), 32'h210);
        chk("t4_count", 32'(n),      32'd10);
        tick;

        // Reset during the access cycle of an AUX write aborts it
        bus.aux_req   = 1'b1;
        bus.aux_we    = 1'b1;
        bus.aux_addr  = 32'h24;
        bus.aux_wdata = 32'h55AA55AA;
        tick;
        reset       = 1'b1;
        bus.aux_req = 1'b0;
        @(negedge clock);
        chk("t5_en_acc", 32'(bus.mem_en), 32'h1);
        tick;
        reset = 1'b0;
        @(negedge clock);
        chk("t5_ack",  32'(bus.aux_ack), 32'h0);
        chk("t5_busy", 32'(bus.busy),    32'h0);
        chk("t5_en",   32'(bus.mem_en),  32'h0);
        tick;
        @(negedge clock);
        chk("t5_ack2", 32'(bus.aux_ack), 32'h0);
        tick;

        // CPU store 0x40 then load 0x40 in the following idle cycle
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h40;
        bus.cpu_wdata = 32'hA5A5A5A5;
        stalls = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            stalls[i] = bus.cpu_stall;
            if (i == 5) chk("t6_rdata", bus.cpu_rdata, 32'hA5A5A5A5);
            tick;
            if (i == 2) bus.cpu_we = 1'b0;
        end
        bus.cpu_req = 1'b0;
        chk("t6_stalls", 32'(stalls), 32'h1B);

        // Randomized traffic, withdrawals and occasional resets
        for (int c = 0; c < 3000; c++) begin
            bit aux_own;
            reset = ($urandom_range(0, 99) == 0);
            if (!bus.cpu_req || cpu_fin) begin
                if ((!bus.cpu_req && $urandom_range(0, 2) == 0) ||
                    (bus.cpu_req && $urandom_range(0, 1) == 0)) begin
                    bus.cpu_req   = 1'b1;
                    bus.cpu_we    = 1'($urandom_range(0, 1));
                    bus.cpu_addr  = 32'($urandom_range(0, 63)) << 2;
                    bus.cpu_wdata = $urandom;
                end else begin
                    bus.cpu_req = 1'b0;
                end
            end
            aux_own = (m_left > 0) && (m_owner == 1);
            if ((!bus.aux_req && !aux_own) || (bus.aux_req && aux_fin)) begin
                if ((!bus.aux_req && $urandom_range(0, 3) == 0) ||
                    (bus.aux_req && $urandom_range(0, 1) == 0)) begin
                    bus.aux_req   = 1'b1;
                    bus.aux_we    = 1'($urandom_range(0, 1));
                    bus.aux_addr  = 32'($urandom_range(0, 63)) << 2;
                    bus.aux_wdata = $urandom;
                end else begin
                    bus.aux_req = 1'b0;
                end
            end else if (bus.aux_req && aux_own && $urandom_range(0, 7) == 0) begin
                bus.aux_req = 1'b0;
            end
            tick;
        end
        reset       = 1'b0;
        bus.cpu_req = 1'b0;
        bus.aux_req = 1'b0;
        repeat (4) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
